// File: rtl/mc_cpu_core_if.sv
// Memory bus of the multi-cycle core.
// A transfer completes on a rising edge with mem_req & mem_ready.
interface mc_cpu_core_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-like core: FETCH/DECODE/EXEC/MEM/WB over one memory port.
// Define OVF_TRAP_EN to trap on signed overflow of ADD/SUB/ADDI.
module mc_cpu_core #(
  parameter int              DATA_W   = 32,
  parameter int              NREGS    = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  mc_cpu_core_if.master bus,
  output logic          halted,
  output logic          exc,
  output logic [2:0]    state_dbg
);
  localparam int AW  = $clog2(NREGS);
  localparam int MSB = DATA_W - 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic              we_rf;
  logic [AW-1:0]     wa;
  logic [DATA_W-1:0] wd;

  logic [5:0]        op, funct;
  logic [AW-1:0]     rs, rt, rd;
  logic [DATA_W-1:0] simm, alu_res;
  logic              ovf;
  logic is_add, is_sub, is_and, is_or, is_slt, is_r;
  logic is_addi, is_lw, is_sw, is_beq, is_j;

  assign op    = ir_q[31:26];
  assign funct = ir_q[5:0];
  assign rs    = ir_q[21 +: AW];
  assign rt    = ir_q[16 +: AW];
  assign rd    = ir_q[11 +: AW];
  assign simm  = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};

  assign is_add  = (op == OP_R) && (funct == F_ADD);
  assign is_sub  = (op == OP_R) && (funct == F_SUB);
  assign is_and  = (op == OP_R) && (funct == F_AND);
  assign is_or   = (op == OP_R) && (funct == F_OR);
  assign is_slt  = (op == OP_R) && (funct == F_SLT);
  assign is_r    = is_add | is_sub | is_and | is_or | is_slt;
  assign is_addi = (op == OP_ADDI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);

  // Default result is A + imm: that is also the LW/SW effective address.
  always_comb begin
    alu_res = a_q + simm;
    ovf     = 1'b0;
    unique case (1'b1)
      is_add: begin
        alu_res = a_q + b_q;
        ovf = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      is_sub: begin
        alu_res = a_q - b_q;
        ovf = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      is_and: alu_res = a_q & b_q;
      is_or:  alu_res = a_q | b_q;
      is_slt: alu_res = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      is_addi: begin
        ovf = (a_q[MSB] == simm[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    we_rf   = 1'b0;
    wa      = rd;
    wd      = alu_q;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = pc_q;
    unique case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata[31:0];
          pc_d    = pc_q + DATA_W'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = regs_q[rs];
        b_d     = regs_q[rt];
        state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_d   = alu_res;
        state_d = S_FETCH;
        if (is_r || is_addi) state_d = S_WB;
        if (is_lw || is_sw)  state_d = S_MEM;
        if (is_beq && (a_q == b_q)) pc_d = pc_q + (simm << 2);
        if (is_j) pc_d = {pc_q[MSB:28], ir_q[25:0], 2'b00};
`ifdef OVF_TRAP_EN
        // PC already holds faulting address + 4.
        if (ovf) state_d = S_TRAP;
`endif
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = is_sw;
        bus.mem_addr = alu_q;
        if (bus.mem_ready) begin
          if (is_lw) begin
            mdr_d   = bus.mem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        we_rf = 1'b1;
        if (is_lw) begin
          wa = rt;
          wd = mdr_q;
        end else if (is_addi) begin
          wa = rt;
        end
        state_d = S_FETCH;
      end
      S_HALT, S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
    // Request must drop the instant reset asserts, even mid-transfer.
    if (!reset) bus.mem_req = 1'b0;
  end

  assign bus.mem_wdata = b_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (we_rf && (wa != '0)) regs_q[wa] <= wd;
    end
  end

  assign halted    = (state_q == S_HALT);
  assign state_dbg = state_q;

  logic unused_bits;
`ifdef OVF_TRAP_EN
  assign exc = (state_q == S_TRAP);
  assign unused_bits = ^{ir_q[10:6], ir_q[25:21]};
`else
  assign exc = 1'b0;
  assign unused_bits = ^{ir_q[10:6], ir_q[25:21], ovf};
`endif
endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: vector table, hand-written corner sequences,
// and random programs checked against an instruction-level model.
module tb_mc_cpu_core;
  localparam int DW = 32;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_NOP  = 6'h0F;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  funct;
    logic [31:0] exp_data;
    int          exp_cyc;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rdy = 1'b0;
  logic halted, exc;
  logic [2:0] state_dbg;

  logic [31:0] mem [256];
  logic [31:0] mm  [256];
  logic [31:0] prog [$];
  txn_t act_q [$];
  txn_t exp_q [$];
  int rdy_mode;
  logic rdy_man;
  int checks = 0;
  int errors = 0;
  int exp_cyc;
  logic exp_halt, exp_trap;

  mc_cpu_core_if #(.DATA_W(DW)) bus ();

  mc_cpu_core #(
    .DATA_W(DW), .NREGS(32), .RESET_PC(32'h0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .halted(halted),
    .exc(exc),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  assign bus.mem_ready = rdy;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] tbits(txn_t t);
    return {28'h0, t.addr, 3'b000, t.we, t.data};
  endfunction

  function automatic logic [31:0] act_addr(int i);
    return (act_q.size() > i) ? act_q[i].addr : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs,
                                        logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd, logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'h00, f};
  endfunction

  function automatic logic [31:0] rand_instr(int i);
    logic [4:0] s = 5'($urandom_range(0, 7));
    logic [4:0] t = 5'($urandom_range(0, 7));
    logic [4:0] d = 5'($urandom_range(0, 7));
    logic [5:0] fl [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26};
    logic [15:0] dimm = 16'(256 + 4 * $urandom_range(0, 63));
    int sel = int'($urandom_range(0, 8));
    case (sel)
      0, 1: return enc_i(OP_ADDI, s, t, 16'($urandom));
      2, 3: return enc_r(s, t, d, fl[$urandom_range(0, 5)]);
      4: return enc_i(OP_LW, 5'd0, t, dimm);
      5: return enc_i(OP_SW, 5'd0, t, dimm);
      6: return enc_i(OP_BEQ, 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 16'($urandom_range(0, 2)));
      7: return {6'h02, 26'(i + 1 + int'($urandom_range(0, 2)))};
      default: return enc_i(OP_NOP, s, t, 16'($urandom));
    endcase
  endfunction

  // Instruction-level reference: bus transactions, cycle count, end state.
  task automatic run_model();
    logic [31:0] r [32];
    logic [31:0] pc, ins, a, b, imm, res, ea;
    longint      wide;
    logic        wr, ovf;
    logic [4:0]  dst;
    for (int i = 0; i < 32; i++) r[i] = 0;
    pc = 0;
    exp_q.delete();
    exp_cyc = 0;
    exp_halt = 1'b0;
    exp_trap = 1'b0;
    for (int n = 0; n < 200; n++) begin
      exp_q.push_back('{pc, 1'b0, 32'h0});
      ins = mm[pc[9:2]];
      pc  = pc + 4;
      a   = r[ins[25:21]];
      b   = r[ins[20:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      wr  = 1'b0;
      ovf = 1'b0;
      res = 0;
      dst = ins[20:16];
      wide = 0;
      if (ins[31:26] == 6'h3F) begin
        exp_cyc += 2;
        exp_halt = 1'b1;
        break;
      end
      case (ins[31:26])
        6'h00: begin
          wr  = 1'b1;
          dst = ins[15:11];
          case (ins[5:0])
            6'h20: begin
              res = a + b;
              wide = longint'($signed(a)) + longint'($signed(b));
            end
            6'h22: begin
              res = a - b;
              wide = longint'($signed(a)) - longint'($signed(b));
            end
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: wr = 1'b0;
          endcase
          if (ins[5:0] == 6'h20 || ins[5:0] == 6'h22)
            ovf = (wide != longint'($signed(res)));
          exp_cyc += wr ? 4 : 3;
        end
        6'h08: begin
          res = a + imm;
          wide = longint'($signed(a)) + longint'($signed(imm));
          ovf = (wide != longint'($signed(res)));
          wr = 1'b1;
          exp_cyc += 4;
        end
        6'h23: begin
          ea = a + imm;
          exp_q.push_back('{ea, 1'b0, 32'h0});
          res = mm[ea[9:2]];
          wr = 1'b1;
          exp_cyc += 5;
        end
        6'h2B: begin
          ea = a + imm;
          exp_q.push_back('{ea, 1'b1, b});
          mm[ea[9:2]] = b;
          exp_cyc += 4;
        end
        6'h04: begin
          if (a == b) pc = pc + (imm << 2);
          exp_cyc += 3;
        end
        6'h02: begin
          pc = {pc[31:28], ins[25:0], 2'b00};
          exp_cyc += 3;
        end
        default: exp_cyc += 3;
      endcase
`ifdef OVF_TRAP_EN
      if (ovf) begin
        exp_trap = 1'b1;
        exp_cyc = exp_cyc - (ins[31:26] == 6'h08 ? 4 : 4) + 3;
        break;
      end
`endif
      if (wr && dst != 0) r[dst] = res;
    end
  endtask

  task automatic drive_sample();
    case (rdy_mode)
      0: rdy = 1'b1;
      1: rdy = ($urandom_range(0, 3) != 0);
      default: rdy = rdy_man;
    endcase
    #1;
    if (bus.mem_req && rdy) begin
      act_q.push_back('{bus.mem_addr, bus.mem_we,
                        bus.mem_we ? bus.mem_wdata : 32'h0});
      if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
    end
  endtask

  task automatic step();
    @(negedge clock);
    drive_sample();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    act_q.delete();
    @(negedge clock);
    reset = 1'b1;
    drive_sample();
  endtask

  task automatic run(input int max, output int cyc);
    cyc = 0;
    while (!(halted || exc) && cyc < max) begin
      step();
      cyc++;
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    foreach (prog[i]) mem[i] = prog[i];
  endtask

  vec_t vecs [9];
  int cyc, nb, bad;
  logic [31:0] nop_w;

  initial begin
    rdy_mode = 2;
    rdy_man  = 1'b0;
    nop_w    = enc_i(OP_NOP, 5'd0, 5'd0, 16'h0);
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_state", 96'(state_dbg), 96'd0);
    chk("rst_req", 96'(bus.mem_req), 96'd0);
    chk("rst_halted", 96'(halted), 96'd0);
    chk("rst_exc", 96'(exc), 96'd0);

    vecs[0] = '{16'd5,    16'd7,    6'h20, 32'd12,        18};
    vecs[1] = '{16'd5,    16'd7,    6'h22, 32'hFFFF_FFFE, 18};
    vecs[2] = '{16'h0F0F, 16'h00FF, 6'h24, 32'h0000_000F, 18};
    vecs[3] = '{16'h0F00, 16'h00F0, 6'h25, 32'h0000_0FF0, 18};
    vecs[4] = '{16'hFFFD, 16'd2,    6'h2A, 32'd1,         18};
    vecs[5] = '{16'd2,    16'hFFFD, 6'h2A, 32'd0,         18};
    vecs[6] = '{16'hFFFF, 16'd1,    6'h20, 32'd0,         18};
    vecs[7] = '{16'h8000, 16'h8000, 6'h20, 32'hFFFF_0000, 18};
    vecs[8] = '{16'd5,    16'd7,    6'h26, 32'd0,         17};

    rdy_mode = 0;
    foreach (vecs[k]) begin
      prog = '{enc_i(OP_ADDI, 5'd0, 5'd1, vecs[k].a),
               enc_i(OP_ADDI, 5'd0, 5'd2, vecs[k].b),
               enc_r(5'd1, 5'd2, 5'd3, vecs[k].funct),
               enc_i(OP_SW, 5'd0, 5'd3, 16'h0040),
               HALT_W};
      load_prog();
      do_reset();
      run(100, cyc);
      chk("vec_halted", 96'(halted), 96'd1);
      chk("vec_cycles", 96'(cyc), 96'(vecs[k].exp_cyc));
      chk("vec_ntxn", 96'(act_q.size()), 96'd6);
      if (act_q.size() > 4)
        chk("vec_store", tbits(act_q[4]),
            tbits('{32'h40, 1'b1, vecs[k].exp_data}));
    end

    // Fetch stalled three edges: request held, IR loads on the 4th edge.
    prog = '{enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1), HALT_W};
    load_prog();
    rdy_mode = 2;
    rdy_man  = 1'b0;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      chk("stall_req", 96'(bus.mem_req), 96'd1);
      chk("stall_addr", 96'(bus.mem_addr), 96'd0);
      chk("stall_state", 96'(state_dbg), 96'd0);
      chk("stall_ir", 96'(dut.ir_q), 96'd0);
      if (j == 2) rdy_man = 1'b1;
      step();
    end
    chk("stall_decode", 96'(state_dbg), 96'd1);
    chk("stall_ir_load", 96'(dut.ir_q), 96'(prog[0]));

    // BEQ r0,r0,-1 at 0x8 spins on 0x8.
    rdy_mode = 0;
    prog = '{nop_w, nop_w, enc_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF)};
    load_prog();
    do_reset();
    repeat (14) step();
    chk("beq_loop_a", 96'(act_addr(2)), 96'h8);
    chk("beq_loop_b", 96'(act_addr(3)), 96'h8);
    chk("beq_loop_c", 96'(act_addr(4)), 96'h8);
    chk("beq_loop_nohalt", 96'(halted), 96'd0);

    // BEQ not taken falls through to 0xC.
    prog = '{enc_i(OP_ADDI, 5'd0, 5'd1, 16'd3), nop_w,
             enc_i(OP_BEQ, 5'd1, 5'd0, 16'hFFFF), HALT_W};
    load_prog();
    do_reset();
    run(100, cyc);
    chk("beq_nt_addr", 96'(act_addr(3)), 96'hC);
    chk("beq_nt_halt", 96'(halted), 96'd1);

    // r0 stays zero.
    prog = '{enc_i(OP_ADDI, 5'd0, 5'd0, 16'd9),
             enc_r(5'd0, 5'd0, 5'd4, 6'h20),
             enc_i(OP_SW, 5'd0, 5'd4, 16'h0040), HALT_W};
    load_prog();
    mem[16] = 32'h0000_DEAD;
    do_reset();
    run(100, cyc);
    chk("r0_store", (act_q.size() > 3) ? tbits(act_q[3]) : 96'hBAD,
        tbits('{32'h40, 1'b1, 32'h0}));

    // Signed overflow on ADDI.
    prog = '{enc_i(OP_LW, 5'd0, 5'd1, 16'h0100),
             enc_i(OP_ADDI, 5'd1, 5'd2, 16'd1),
             enc_i(OP_SW, 5'd0, 5'd2, 16'h0044), HALT_W};
    load_prog();
    mem[64] = 32'h7FFF_FFFF;
    do_reset();
    run(100, cyc);
`ifdef OVF_TRAP_EN
    chk("ovf_exc", 96'(exc), 96'd1);
    chk("ovf_state", 96'(state_dbg), 96'd6);
    chk("ovf_r2", 96'(dut.regs_q[2]), 96'd0);
    chk("ovf_pc", 96'(dut.pc_q), 96'h8);
    chk("ovf_ntxn", 96'(act_q.size()), 96'd3);
`else
    chk("ovf_exc", 96'(exc), 96'd0);
    chk("ovf_store", (act_q.size() > 4) ? tbits(act_q[4]) : 96'hBAD,
        tbits('{32'h44, 1'b1, 32'h8000_0000}));
`endif

    // Reset during a stalled store.
    prog = '{enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1),
             enc_i(OP_SW, 5'd0, 5'd1, 16'h0048), HALT_W};
    load_prog();
    mem[18] = 32'h0;
    rdy_mode = 2;
    rdy_man  = 1'b1;
    do_reset();
    repeat (6) step();
    rdy_man = 1'b0;
    repeat (2) step();
    chk("mw_state", 96'(state_dbg), 96'd3);
    chk("mw_req_we", 96'({bus.mem_req, bus.mem_we}), 96'd3);
    chk("mw_addr", 96'(bus.mem_addr), 96'h48);
    #1 reset = 1'b0;
    #1;
    chk("mw_req_drop", 96'(bus.mem_req), 96'd0);
    nb = act_q.size();
    rdy_man = 1'b1;
    repeat (2) step();
    chk("mw_no_txn", 96'(act_q.size()), 96'(nb));
    chk("mw_no_write", 96'(mem[18]), 96'd0);
    chk("mw_state_rst", 96'(state_dbg), 96'd0);
    do_reset();
    chk("mw_refetch", 96'(act_addr(0)), 96'd0);
    run(100, cyc);
    chk("mw_final", 96'(mem[18]), 96'd1);

    // Random programs against the reference model.
    for (int t = 0; t < 30; t++) begin
      int n = int'($urandom_range(8, 20));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(rand_instr(i));
      load_prog();
      for (int w = 64; w < 128; w++) mem[w] = $urandom;
      mm = mem;
      run_model();
      rdy_mode = (t % 2 == 0) ? 0 : 1;
      do_reset();
      run(3000, cyc);
      chk("rnd_end", 96'({halted, exc}), 96'({exp_halt, exp_trap}));
      if (rdy_mode == 0) chk("rnd_cycles", 96'(cyc), 96'(exp_cyc));
      chk("rnd_ntxn", 96'(act_q.size()), 96'(exp_q.size()));
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
        chk("rnd_txn", tbits(act_q[i]), tbits(exp_q[i]));
      bad = 0;
      for (int w = 64; w < 128; w++) if (mem[w] !== mm[w]) bad++;
      chk("rnd_dmem", 96'(bad), 96'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_cpu_core.md
MC_CPU_CORE -- requirements
Module: mc_cpu_core

Interface
REQ-001 Parameter DATA_W, default 32, datapath/register/address width; legal values 32 or 64.
REQ-002 Parameter NREGS, default 32, register count; power of two, 8..32; index = low log2(NREGS) bits of the rs/rt/rd fields.
REQ-003 Parameter RESET_PC, default 0, byte address of the first fetch.
REQ-004 clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 mem_addr  out  DATA_W  byte address of the current memory request.
REQ-007 mem_wdata  out  DATA_W  store data; value B.
REQ-008 mem_rdata  in  DATA_W  read data; the instruction is mem_rdata[31:0].
REQ-009 mem_req  out  1  memory request valid.
REQ-010 mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req = 1.
REQ-011 mem_ready  in  1  transfer completes on a rising edge where mem_req & mem_ready.
REQ-012 halted  out  1  core stopped on HALT.
REQ-013 exc  out  1  overflow trap taken; port always present.
REQ-014 state_dbg  out  3  current FSM state encoding.

Function
REQ-015 Encoding: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0]; imm sign-extended to DATA_W.
REQ-016 Supported: R-type (op 0x00; funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A signed); ADDI 0x08; LW 0x23; SW 0x2B; BEQ 0x04; J 0x02; HALT 0x3F.
REQ-017 Any other opcode/funct executes as a NOP: PC advances, no write, no memory access.
REQ-018 States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), HALT(5), TRAP(6).
REQ-019 FETCH: mem_req = 1, mem_we = 0, mem_addr = PC; hold until the completing edge; at that edge IR <= rdata[31:0], PC <= PC+4, go to DECODE.
REQ-020 DECODE: A <= R[rs], B <= R[rt]; go to EXEC; HALT opcode goes to HALT.
REQ-021 EXEC: ALUOut <= result; R-type/ADDI -> WB; LW/SW -> MEM; BEQ: if A == B then PC <= PC + (sext(imm) << 2); J: PC <= {PC[DATA_W-1:28], instr[25:0], 2'b00}; BEQ/J/NOP -> FETCH.
REQ-022 MEM: mem_req = 1, mem_addr = A + sext(imm), mem_we = 1 for SW; hold until completing edge; LW latches MDR and goes to WB; SW goes to FETCH.
REQ-023 WB: R-type writes R[rd]; ADDI writes R[rt] with ALUOut; LW writes R[rt] with MDR; go to FETCH.
REQ-024 R0 reads as 0; writes to R0 are discarded.
REQ-025 mem_req = 0 in DECODE, EXEC, WB, HALT and TRAP; mem_addr, mem_we and mem_wdata stay stable while mem_req = 1 and ready = 0.
REQ-026 Arithmetic wraps modulo 2^DATA_W; SLT writes 1/0 zero-extended.
REQ-027 Latency with mem_ready tied high: R-type/ADDI 4 cycles, LW 5, SW 4, BEQ/J/NOP 3.
REQ-028 HALT: halted = 1, no further requests; left only by reset.

Reset
REQ-029 While reset = 0: PC = RESET_PC, state = FETCH, all registers/IR/A/B/ALUOut/MDR = 0, halted = 0, exc = 0.
REQ-030 mem_req goes low asynchronously on reset assertion, including mid-transfer; the first request after deassertion is a fetch from RESET_PC.

Configuration
REQ-031 Macro OVF_TRAP_EN defined: signed overflow on ADD/SUB/ADDI in EXEC suppresses WB and enters TRAP; TRAP sets exc = 1 and PC = faulting address + 4; TRAP is left only by reset.
REQ-032 OVF_TRAP_EN undefined: the overflowing result is written back wrapped, TRAP is unreachable, and exc is tied to 0.

Verification
REQ-033 ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; SW r3,0x40(r0); HALT, ready = 1 -> write to 0x40 with data 12; halted = 1 after 4+4+4+4+2 cycles.
REQ-034 ready low for 3 cycles in FETCH -> mem_req and mem_addr are held constant; IR is loaded only on the 4th edge.
REQ-035 BEQ r0,r0,-1 at 0x8 -> next fetch from 0x8; BEQ r1,r0 with r1 != 0 -> fetch from 0xC.
REQ-036 ADDI r0,r0,9 then ADD r4,r0,r0 -> r4 = 0.
REQ-037 OVF_TRAP_EN, DATA_W = 32, r1 = 0x7FFFFFFF, ADDI r2,r1,1 -> exc = 1, r2 unchanged, state_dbg = 6; without macro, r2 = 0x80000000.
REQ-038 reset pulsed during SW MEM wait -> mem_req drops immediately, no write completes, fetch restarts at RESET_PC.
